// File: rtl/adder_precision_scheduler_if.sv
// Requester-side bundle for the precision scheduler: operation requests in,
// per-requester results out. The scheduler takes the slave view.
interface adder_precision_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int LANE_W = 8,
    parameter int PREC_W = 2
);
    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0]                 req_ready;
    logic [N_REQ-1:0][PREC_W-1:0]     req_prec;
    logic [N_REQ-1:0][4*LANE_W-1:0]   req_in0;
    logic [N_REQ-1:0][4*LANE_W-1:0]   req_in1;
    logic [N_REQ-1:0]                 resp_valid;
    logic [N_REQ-1:0][4*LANE_W:0]     resp_data;

    modport master (
        output req_valid, req_prec, req_in0, req_in1,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_prec, req_in0, req_in1,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/adder_precision_scheduler.sv
// Shares one 4-lane precision-decomposable adder among N_REQ requesters.
// Each cycle one precision is chosen (head of the round-robin scan), up to
// 4/2/1 same-precision ops are packed into lanes, added in stage 1 and the
// per-slot sums are returned to their owners from stage 2.
module adder_precision_scheduler #(
    parameter int N_REQ              = 4,
    parameter int LANE_W             = 8,
    parameter int CNT_W              = 16,
    parameter int PRECISION_CONFIG_L = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    adder_precision_scheduler_if.slave    bus,
    input  logic                          stat_clr,
    output logic [PRECISION_CONFIG_L-1:0] issue_mode,
    output logic [CNT_W-1:0]              stat_issue_cnt,
    output logic [CNT_W-1:0]              stat_op_cnt
);
    localparam int DATA_W = 4 * LANE_W;
    localparam int RES_W  = DATA_W + 1;
    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OP_W   = CNT_W + 1;

    typedef logic [PRECISION_CONFIG_L-1:0] prec_t;
    localparam prec_t PRECISION_CONFIG_8B  = prec_t'(0);
    localparam prec_t PRECISION_CONFIG_16B = prec_t'(1);
    localparam prec_t PRECISION_CONFIG_32B = prec_t'(2);

    // Anything that is not a known narrow encoding runs as a full 32 b op.
    function automatic prec_t norm_prec(input prec_t p);
        if (p == PRECISION_CONFIG_8B || p == PRECISION_CONFIG_16B) return p;
        return PRECISION_CONFIG_32B;
    endfunction

    logic [PTR_W-1:0]            rr_ptr;
    logic [PTR_W-1:0]            head_idx;
    logic                        any_sel;
    logic [N_REQ-1:0]            sel;
    prec_t                       sel_mode;
    logic [3:0][PTR_W-1:0]       slot_req;
    logic [3:0]                  slot_used;
    logic [DATA_W-1:0]           pack0, pack1;

    logic                        s1_valid;
    prec_t                       s1_mode;
    logic [DATA_W-1:0]           s1_in0, s1_in1;
    logic [3:0][PTR_W-1:0]       s1_slot_req;
    logic [3:0]                  s1_slot_used;

    logic [3:0][LANE_W-1:0]      lane_sum;
    logic [3:0]                  lane_co;
    logic [3:0][RES_W-1:0]       slot_res;

    logic [N_REQ-1:0]            resp_valid_nxt, resp_valid_q;
    logic [N_REQ-1:0][RES_W-1:0] resp_data_nxt, resp_data_q;
    logic [OP_W-1:0]             op_sum;

    assign bus.req_ready  = sel;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign issue_mode     = s1_mode;

    // Round-robin scan: first valid requester fixes the mode, later ones of
    // the same precision fill the remaining slots in scan order.
    always_comb begin
        int idx;
        int n_sel;
        int cap;
        idx       = 0;
        n_sel     = 0;
        cap       = 1;
        sel       = '0;
        any_sel   = 1'b0;
        head_idx  = '0;
        sel_mode  = PRECISION_CONFIG_32B;
        slot_req  = '0;
        slot_used = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (bus.req_valid[idx]) begin
                if (!any_sel) begin
                    any_sel  = 1'b1;
                    head_idx = PTR_W'(idx);
                    sel_mode = norm_prec(bus.req_prec[idx]);
                    cap      = (sel_mode == PRECISION_CONFIG_8B)  ? 4 :
                               (sel_mode == PRECISION_CONFIG_16B) ? 2 : 1;
                end
                if (norm_prec(bus.req_prec[idx]) == sel_mode && n_sel < cap) begin
                    sel[idx]               = 1'b1;
                    slot_req[n_sel[1:0]]   = PTR_W'(idx);
                    slot_used[n_sel[1:0]]  = 1'b1;
                    n_sel                  = n_sel + 1;
                end
            end
        end
    end

    // Pack selected operands into lanes; unused lanes stay zero.
    always_comb begin
        pack0 = '0;
        pack1 = '0;
        case (sel_mode)
            PRECISION_CONFIG_8B: begin
                for (int s = 0; s < 4; s++) begin
                    if (slot_used[s]) begin
                        pack0[s*LANE_W +: LANE_W] = bus.req_in0[slot_req[s]][LANE_W-1:0];
                        pack1[s*LANE_W +: LANE_W] = bus.req_in1[slot_req[s]][LANE_W-1:0];
                    end
                end
            end
            PRECISION_CONFIG_16B: begin
                for (int s = 0; s < 2; s++) begin
                    if (slot_used[s]) begin
                        pack0[s*2*LANE_W +: 2*LANE_W] = bus.req_in0[slot_req[s]][2*LANE_W-1:0];
                        pack1[s*2*LANE_W +: 2*LANE_W] = bus.req_in1[slot_req[s]][2*LANE_W-1:0];
                    end
                end
            end
            default: begin
                if (slot_used[0]) begin
                    pack0 = bus.req_in0[slot_req[0]];
                    pack1 = bus.req_in1[slot_req[0]];
                end
            end
        endcase
    end

    // Round-robin pointer moves past the head on every accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (any_sel) begin
            rr_ptr <= (head_idx == PTR_W'(N_REQ - 1)) ? '0 : head_idx + 1'b1;
        end
    end

    // Issue register; mode and operands hold while idle so issue_mode keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_mode      <= PRECISION_CONFIG_32B;
            s1_in0       <= '0;
            s1_in1       <= '0;
            s1_slot_req  <= '0;
            s1_slot_used <= '0;
        end else begin
            s1_valid <= any_sel;
            if (any_sel) begin
                s1_mode      <= sel_mode;
                s1_in0       <= pack0;
                s1_in1       <= pack1;
                s1_slot_req  <= slot_req;
                s1_slot_used <= slot_used;
            end
        end
    end

    // Decomposable adder: carry is cut at every lane (8B), at lane 2 (16B) or never (32B).
    always_comb begin
        logic             carry;
        logic [LANE_W:0]  t;
        carry    = 1'b0;
        t        = '0;
        lane_sum = '0;
        lane_co  = '0;
        for (int l = 0; l < 4; l++) begin
            if (l == 0 || s1_mode == PRECISION_CONFIG_8B ||
                (s1_mode == PRECISION_CONFIG_16B && l == 2)) begin
                carry = 1'b0;
            end
            t = {1'b0, s1_in0[l*LANE_W +: LANE_W]} + {1'b0, s1_in1[l*LANE_W +: LANE_W]}
                + {{LANE_W{1'b0}}, carry};
            lane_sum[l] = t[LANE_W-1:0];
            lane_co[l]  = t[LANE_W];
            carry       = t[LANE_W];
        end
    end

    // Gather each slot's sum with its own carry-out, zero-extended.
    always_comb begin
        slot_res = '0;
        case (s1_mode)
            PRECISION_CONFIG_8B: begin
                for (int s = 0; s < 4; s++) begin
                    slot_res[s] = RES_W'({lane_co[s], lane_sum[s]});
                end
            end
            PRECISION_CONFIG_16B: begin
                for (int s = 0; s < 2; s++) begin
                    slot_res[s] = RES_W'({lane_co[2*s+1], lane_sum[2*s+1], lane_sum[2*s]});
                end
            end
            default: slot_res[0] = {lane_co[3], lane_sum};
        endcase
    end

    // Route used slots back to their owners; other requesters keep their last result.
    always_comb begin
        resp_valid_nxt = '0;
        resp_data_nxt  = resp_data_q;
        if (s1_valid) begin
            for (int s = 0; s < 4; s++) begin
                if (s1_slot_used[s]) begin
                    resp_valid_nxt[s1_slot_req[s]] = 1'b1;
                    resp_data_nxt[s1_slot_req[s]]  = slot_res[s];
                end
            end
        end
    end

    // Result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= resp_valid_nxt;
            resp_data_q  <= resp_data_nxt;
        end
    end

    assign op_sum = {1'b0, stat_op_cnt} + OP_W'($countones(sel));

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issue_cnt <= '0;
            stat_op_cnt    <= '0;
        end else if (stat_clr) begin
            stat_issue_cnt <= '0;
            stat_op_cnt    <= '0;
        end else if (any_sel) begin
            stat_issue_cnt <= (&stat_issue_cnt) ? stat_issue_cnt : stat_issue_cnt + 1'b1;
            stat_op_cnt    <= op_sum[CNT_W] ? {CNT_W{1'b1}} : op_sum[CNT_W-1:0];
        end
    end
endmodule
